// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU/MDU: operation codes, FSM states and
// the op classification helpers used by the top level and the iterative unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OpNop   = 4'h0,
        OpAdd   = 4'h1,
        OpSub   = 4'h2,
        OpSll   = 4'h3,
        OpSlt   = 4'h4,
        OpSltu  = 4'h5,
        OpXor   = 4'h6,
        OpSrl   = 4'h7,
        OpSra   = 4'h8,
        OpOr    = 4'h9,
        OpAnd   = 4'hA,
        OpMul   = 4'hB,
        OpMulhu = 4'hC,
        OpDivu  = 4'hD,
        OpRemu  = 4'hE,
        OpZero  = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } alu_state_t;

    function automatic logic is_multicycle(input alu_op_t op);
        return (op == OpMul) || (op == OpMulhu) || (op == OpDivu) || (op == OpRemu);
    endfunction

    function automatic logic is_div(input alu_op_t op);
        return (op == OpDivu) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per
// cycle over WIDTH cycles; result is valid combinationally alongside done.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic               active;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    alu_op_t            op_q;
    logic               dz_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic               last;

    // acc holds {hi, lo}: product high/low for multiply, remainder/quotient for divide.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (is_div(op_q)) begin
            if (trial[WIDTH]) begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    assign last   = (cnt == CW'(WIDTH - 1));
    assign done   = active && last;
    assign dz     = dz_q;
    assign result = ((op_q == OpMul) || (op_q == OpDivu)) ? acc_next[WIDTH-1:0]
                                                          : acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            op_q    <= OpNop;
            dz_q    <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, (is_div(op) ? a : b)};
            operand <= is_div(op) ? b : a;
            op_q    <= op;
            dz_q    <= is_div(op) && (b == '0);
        end else if (active) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked ALU with iterative multiply/divide: single-cycle ops register in
// one cycle, mul/div ops stall in BUSY for WIDTH cycles.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic [WIDTH-1:0] in2_data,
    input  logic [3:0]       alu_operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             div_by_zero
);
    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_t       state;
    alu_op_t          op_in;
    logic             accept;
    logic             md_start;
    logic             md_done;
    logic             md_dz;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;

    assign op_in    = alu_op_t'(alu_operation);
    assign shamt    = in2_data[SHW-1:0];
    assign in_ready = (state == StIdle) || ((state == StDone) && out_ready);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_multicycle(op_in);

    always_comb begin
        alu_res = '0;
        case (op_in)
            OpAdd:   alu_res = in1_data + in2_data;
            OpSub:   alu_res = in1_data - in2_data;
            OpSll:   alu_res = in1_data << shamt;
            OpSlt:   alu_res = ($signed(in1_data) < $signed(in2_data)) ? '1 : '0;
            OpSltu:  alu_res = (in1_data < in2_data) ? '1 : '0;
            OpXor:   alu_res = in1_data ^ in2_data;
            OpSrl:   alu_res = in1_data >> shamt;
            OpSra:   alu_res = WIDTH'($signed(in1_data) >>> shamt);
            OpOr:    alu_res = in1_data | in2_data;
            OpAnd:   alu_res = in1_data & in2_data;
            default: alu_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (op_in),
        .a      (in1_data),
        .b      (in2_data),
        .done   (md_done),
        .result (md_result),
        .dz     (md_dz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            out_valid   <= 1'b0;
            out_data    <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    // A DONE result not yet taken holds everything in place.
                    if ((state == StIdle) || out_ready) begin
                        if (accept && is_multicycle(op_in)) begin
                            state     <= StBusy;
                            out_valid <= 1'b0;
                        end else if (accept) begin
                            state       <= StDone;
                            out_valid   <= 1'b1;
                            out_data    <= alu_res;
                            div_by_zero <= 1'b0;
                        end else begin
                            state     <= StIdle;
                            out_valid <= 1'b0;
                        end
                    end
                end
                StBusy: begin
                    if (md_done) begin
                        state       <= StDone;
                        out_valid   <= 1'b1;
                        out_data    <= md_result;
                        div_by_zero <= md_dz;
                    end
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
